regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised 2-read/2-write register file. Successor to the single-write
//  32x32 register file. Adds configurable width and depth, a second write
//  port, byte-enable writes, a hardwired-zero R0 option, write-to-read
//  bypass and an optional registered read stage. Sits in the CPU decode
//  stage (reads) and the writeback stage (writes).
// PARAMETERS
//  DATA_W    32  data width in bits; must be a multiple of 8
//  ADDR_W    5   address width; depth = 2**ADDR_W
//  ZERO_REG  1   1: R0 reads 0 and ignores writes; 0: R0 is an ordinary register
//  BYPASS    1   1: a same-cycle write is forwarded to a matching read; 0: old data is read
//  READ_LAT  0   0: combinational read; 1: read data registered (1-cycle latency)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  rd_addrA   in   ADDR_W    read port A address
//  rd_addrB   in   ADDR_W    read port B address
//  rd_dataA   out  DATA_W    read port A data
//  rd_dataB   out  DATA_W    read port B data
//  wr_en0     in   1         write port 0 enable
//  wr_be0     in   DATA_W/8  write port 0 byte enables (bit i -> byte i)
//  wr_addr0   in   ADDR_W    write port 0 address
//  wr_data0   in   DATA_W    write port 0 data
//  wr_en1     in   1         write port 1 enable (full-word only)
//  wr_addr1   in   ADDR_W    write port 1 address
//  wr_data1   in   DATA_W    write port 1 data
//  wr_conflict out 1         registered: both ports wrote the same address last cycle
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-high.
//  - Reset: all registers are 0. The rd_data registers (READ_LAT=1) and wr_conflict
//    are 0. Reset wins over any write in the same cycle.
//  - Write port 0: on a clk edge with wr_en0=1, each byte i with wr_be0[i]=1 is updated.
//    wr_be0=0 is a legal no-op.
//  - Write port 1: on a clk edge with wr_en1=1, the full word is written.
//  - Same address on both ports, both enabled: port 1 wins for every byte.
//    wr_conflict=1 on the following cycle. Otherwise wr_conflict=0.
//  - ZERO_REG=1: writes to address 0 are dropped, and reads of address 0 return 0
//    (no bypass). A conflict on address 0 still sets wr_conflict.
//  - Read, READ_LAT=0: rd_data follows the address combinationally.
//    - BYPASS=1: on an address match the result is the merged same-cycle write
//      (port 1 word, else port 0 bytes over the stored word).
//    - BYPASS=0: the stored value is returned; new data is visible after the edge.
//  - Read, READ_LAT=1: the READ_LAT=0 result is captured at clk, so rd_data is valid
//    1 cycle after the address. With BYPASS=0, the captured value is pre-write data.
//  - Port A and port B are independent. Both may read the same address.
//  - Address width is exact: no wrap or aliasing, and every address is a valid register.
// STRUCTURE
//  - Shared header regfile_defs.vh holds the default widths, the ZERO_REG/BYPASS
//    encodings and a byte-merge function.
//  - One sub-module, regfile_rd_port. It is instantiated twice (A, B) and contains
//    the zero check, the bypass compare/merge mux and the optional output register.
//  - The storage array and write logic stay in regfile_mp.
// TESTING  (defaults unless stated)
//  1. Reset, then wr_en0=1 with be=F, addr 8, data 11111111. Next cycle rd_addrA=8
//     -> rd_dataA=11111111. After rst=1 for one edge -> rd_dataA=0.
//  2. Same cycle: wr_en0 to addr 9 with 22222222, wr_en1 to addr 9 with 33333333.
//     -> reg 9 = 33333333 and wr_conflict=1 for exactly 1 cycle.
//  3. Reg 5 holds AAAAAAAA. wr_en0 be=0101 with data 12345678 -> reg 5 = AA34AA78.
//  4. BYPASS=1: rd_addrB=7 while wr_en1 writes 0000BEEF to 7 -> rd_dataB=0000BEEF
//     in the same cycle. BYPASS=0 -> old value until the edge.
//  5. ZERO_REG=1: write FFFFFFFF to addr 0 on both ports -> rd_dataA(0)=0 and
//     wr_conflict=1. With ZERO_REG=0 -> FFFFFFFF.
//  6. READ_LAT=1: change rd_addrA 3->4 -> rd_dataA updates 1 edge later.
//     rst asserted mid-burst with wr_en0=1 -> all registers 0 and no write lands.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared defaults, option encodings and byte-merge helper for regfile_mp
package regfile_mp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam int ZERO_REG_OFF = 0;
    localparam int ZERO_REG_ON  = 1;
    localparam int BYPASS_OFF   = 0;
    localparam int BYPASS_ON    = 1;
    localparam int READ_LAT_COMB = 0;
    localparam int READ_LAT_REG  = 1;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    // Byte i of the result comes from new_word when be[i] is set, else from old_word.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] result;
        for (int i = 0; i < MAX_BE_W; i++) begin
            result[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write port bundle for the 2R/2W register file
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] rd_addrA;
    logic [ADDR_W-1:0] rd_addrB;
    logic [DATA_W-1:0] rd_dataA;
    logic [DATA_W-1:0] rd_dataB;
    logic              wr_en0;
    logic [BE_W-1:0]   wr_be0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [DATA_W-1:0] wr_data0;
    logic              wr_en1;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data1;
    logic              wr_conflict;

    modport master (
        output rd_addrA, rd_addrB,
        output wr_en0, wr_be0, wr_addr0, wr_data0,
        output wr_en1, wr_addr1, wr_data1,
        input  rd_dataA, rd_dataB, wr_conflict
    );

    modport slave (
        input  rd_addrA, rd_addrB,
        input  wr_en0, wr_be0, wr_addr0, wr_data0,
        input  wr_en1, wr_addr1, wr_data1,
        output rd_dataA, rd_dataB, wr_conflict
    );

endinterface

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one read port: zero check, write bypass and optional output register
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = ZERO_REG_ON,
    parameter int BYPASS   = BYPASS_ON,
    parameter int READ_LAT = READ_LAT_COMB
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   stored,
    input  logic                wr_en0,
    input  logic [DATA_W/8-1:0] wr_be0,
    input  logic [ADDR_W-1:0]   wr_addr0,
    input  logic [DATA_W-1:0]   wr_data0,
    input  logic                wr_en1,
    input  logic [ADDR_W-1:0]   wr_addr1,
    input  logic [DATA_W-1:0]   wr_data1,
    output logic [DATA_W-1:0]   data
);

    logic [DATA_W-1:0] merged0;
    logic [DATA_W-1:0] comb_data;
    logic [DATA_W-1:0] data_q;

    // Port 0 bytes laid over the stored word, as it will look after the edge.
    assign merged0 = DATA_W'(byte_merge(MAX_DATA_W'(stored),
                                        MAX_DATA_W'(wr_data0),
                                        MAX_BE_W'(wr_be0)));

    // Unregistered read result; port 1 takes priority over port 0 like the write side.
    always_comb begin
        comb_data = stored;
        if (ZERO_REG != 0 && addr == '0) begin
            comb_data = '0;
        end else if (BYPASS != 0 && wr_en1 && wr_addr1 == addr) begin
            comb_data = wr_data1;
        end else if (BYPASS != 0 && wr_en0 && wr_addr0 == addr) begin
            comb_data = merged0;
        end
    end

    // Output register; only observed when READ_LAT selects the registered stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= comb_data;
        end
    end

    assign data = (READ_LAT != 0) ? data_q : comb_data;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised 2-read/2-write register file with byte enables and bypass
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,   // multiple of 8
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = ZERO_REG_ON,
    parameter int BYPASS   = BYPASS_ON,
    parameter int READ_LAT = READ_LAT_COMB
) (
    input  logic       clk,
    input  logic       rst,
    regfile_mp_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;
    logic [DATA_W-1:0] merged0;
    logic              wr_ok0;
    logic              wr_ok1;
    logic              conflict_q;

    // R0 swallows writes when hardwired; the conflict flag ignores this filter.
    assign wr_ok0 = bus.wr_en0 && !(ZERO_REG != 0 && bus.wr_addr0 == '0);
    assign wr_ok1 = bus.wr_en1 && !(ZERO_REG != 0 && bus.wr_addr1 == '0);

    assign merged0 = DATA_W'(byte_merge(MAX_DATA_W'(mem[bus.wr_addr0]),
                                        MAX_DATA_W'(bus.wr_data0),
                                        MAX_BE_W'(bus.wr_be0)));

    // Storage update; port 1 is issued last so it overrides port 0 on a shared address.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok0) begin
                mem[bus.wr_addr0] <= merged0;
            end
            if (wr_ok1) begin
                mem[bus.wr_addr1] <= bus.wr_data1;
            end
        end
    end

    // Flag a same-address double write for one cycle after it happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= bus.wr_en0 && bus.wr_en1 && (bus.wr_addr0 == bus.wr_addr1);
        end
    end

    assign bus.wr_conflict = conflict_q;
    assign stored_a = mem[bus.rd_addrA];
    assign stored_b = mem[bus.rd_addrB];

    regfile_rd_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS),
        .READ_LAT(READ_LAT)
    ) u_rd_a (
        .clk     (clk),
        .rst     (rst),
        .addr    (bus.rd_addrA),
        .stored  (stored_a),
        .wr_en0  (bus.wr_en0),
        .wr_be0  (bus.wr_be0),
        .wr_addr0(bus.wr_addr0),
        .wr_data0(bus.wr_data0),
        .wr_en1  (bus.wr_en1),
        .wr_addr1(bus.wr_addr1),
        .wr_data1(bus.wr_data1),
        .data    (bus.rd_dataA)
    );

    regfile_rd_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS),
        .READ_LAT(READ_LAT)
    ) u_rd_b (
        .clk     (clk),
        .rst     (rst),
        .addr    (bus.rd_addrB),
        .stored  (stored_b),
        .wr_en0  (bus.wr_en0),
        .wr_be0  (bus.wr_be0),
        .wr_addr0(bus.wr_addr0),
        .wr_data0(bus.wr_data0),
        .wr_en1  (bus.wr_en1),
        .wr_addr1(bus.wr_addr1),
        .wr_data1(bus.wr_data1),
        .data    (bus.rd_dataB)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed bench for regfile_mp in three parameter configurations
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    // d: defaults; o: ZERO_REG=0, BYPASS=0; r: READ_LAT=1. All share one stimulus.
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus_d ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus_o ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus_r ();

    assign bus_o.rd_addrA = bus_d.rd_addrA;
    assign bus_o.rd_addrB = bus_d.rd_addrB;
    assign bus_o.wr_en0   = bus_d.wr_en0;
    assign bus_o.wr_be0   = bus_d.wr_be0;
    assign bus_o.wr_addr0 = bus_d.wr_addr0;
    assign bus_o.wr_data0 = bus_d.wr_data0;
    assign bus_o.wr_en1   = bus_d.wr_en1;
    assign bus_o.wr_addr1 = bus_d.wr_addr1;
    assign bus_o.wr_data1 = bus_d.wr_data1;

    assign bus_r.rd_addrA = bus_d.rd_addrA;
    assign bus_r.rd_addrB = bus_d.rd_addrB;
    assign bus_r.wr_en0   = bus_d.wr_en0;
    assign bus_r.wr_be0   = bus_d.wr_be0;
    assign bus_r.wr_addr0 = bus_d.wr_addr0;
    assign bus_r.wr_data0 = bus_d.wr_data0;
    assign bus_r.wr_en1   = bus_d.wr_en1;
    assign bus_r.wr_addr1 = bus_d.wr_addr1;
    assign bus_r.wr_data1 = bus_d.wr_data1;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .READ_LAT(0))
        dut_d (.clk(clk), .rst(rst), .bus(bus_d));
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0), .READ_LAT(0))
        dut_o (.clk(clk), .rst(rst), .bus(bus_o));
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .READ_LAT(1))
        dut_r (.clk(clk), .rst(rst), .bus(bus_r));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes;
        bus_d.wr_en0   = 1'b0;
        bus_d.wr_be0   = 4'h0;
        bus_d.wr_addr0 = 5'd0;
        bus_d.wr_data0 = 32'h0;
        bus_d.wr_en1   = 1'b0;
        bus_d.wr_addr1 = 5'd0;
        bus_d.wr_data1 = 32'h0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_writes();
        bus_d.rd_addrA = 5'd8;
        bus_d.rd_addrB = 5'd9;
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (bus_d.rd_dataA !== 32'h0) begin
            failed++;
            $display("FAIL reset_rdA_d: got %h want %h", bus_d.rd_dataA, 32'h0);
        end
        tests++;
        if (bus_d.wr_conflict !== 1'b0) begin
            failed++;
            $display("FAIL reset_conflict_d: got %b want 0", bus_d.wr_conflict);
        end
        tests++;
        if (bus_r.rd_dataB !== 32'h0) begin
            failed++;
            $display("FAIL reset_rdB_r: got %h want %h", bus_r.rd_dataB, 32'h0);
        end
    endtask

    task automatic test_basic_write;
        bus_d.wr_en0   = 1'b1;
        bus_d.wr_be0   = 4'hF;
        bus_d.wr_addr0 = 5'd8;
        bus_d.wr_data0 = 32'h11111111;
        tick();
        idle_writes();
        bus_d.rd_addrA = 5'd8;
        #1;
        tests++;
        if (bus_d.rd_dataA !== 32'h11111111) begin
            failed++;
            $display("FAIL basic_rdA_d: got %h want %h", bus_d.rd_dataA, 32'h11111111);
        end
        tests++;
        if (bus_o.rd_dataA !== 32'h11111111) begin
            failed++;
            $display("FAIL basic_rdA_o: got %h want %h", bus_o.rd_dataA, 32'h11111111);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (bus_d.rd_dataA !== 32'h0) begin
            failed++;
            $display("FAIL basic_after_rst_d: got %h want %h", bus_d.rd_dataA, 32'h0);
        end
    endtask

    task automatic test_conflict;
        bus_d.wr_en0   = 1'b1;
        bus_d.wr_be0   = 4'hF;
        bus_d.wr_addr0 = 5'd9;
        bus_d.wr_data0 = 32'h22222222;
        bus_d.wr_en1   = 1'b1;
        bus_d.wr_addr1 = 5'd9;
        bus_d.wr_data1 = 32'h33333333;
        bus_d.rd_addrA = 5'd9;
        #1;
        tests++;
        if (bus_d.rd_dataA !== 32'h33333333) begin
            failed++;
            $display("FAIL conflict_bypass_d: got %h want %h", bus_d.rd_dataA, 32'h33333333);
        end
        tests++;
        if (bus_o.rd_dataA !== 32'h0) begin
            failed++;
            $display("FAIL conflict_nobypass_o: got %h want %h", bus_o.rd_dataA, 32'h0);
        end
        tests++;
        if (bus_d.wr_conflict !== 1'b0) begin
            failed++;
            $display("FAIL conflict_pre_edge: got %b want 0", bus_d.wr_conflict);
        end
        tick();
        idle_writes();
        #1;
        tests++;
        if (bus_d.wr_conflict !== 1'b1) begin
            failed++;
            $display("FAIL conflict_flag: got %b want 1", bus_d.wr_conflict);
        end
        tests++;
        if (bus_o.rd_dataA !== 32'h33333333) begin
            failed++;
            $display("FAIL conflict_winner_o: got %h want %h", bus_o.rd_dataA, 32'h33333333);
        end
        tick();
        tests++;
        if (bus_d.wr_conflict !== 1'b0) begin
            failed++;
            $display("FAIL conflict_one_cycle: got %b want 0", bus_d.wr_conflict);
        end
    endtask

    task automatic test_byte_enable;
        bus_d.wr_en1   = 1'b1;
        bus_d.wr_addr1 = 5'd5;
        bus_d.wr_data1 = 32'hAAAAAAAA;
        tick();
        idle_writes();
        bus_d.wr_en0   = 1'b1;
        bus_d.wr_be0   = 4'b0101;
        bus_d.wr_addr0 = 5'd5;
        bus_d.wr_data0 = 32'h12345678;
        bus_d.rd_addrB = 5'd5;
        #1;
        tests++;
        if (bus_d.rd_dataB !== 32'hAA34AA78) begin
            failed++;
            $display("FAIL be_bypass_d: got %h want %h", bus_d.rd_dataB, 32'hAA34AA78);
        end
        tests++;
        if (bus_o.rd_dataB !== 32'hAAAAAAAA) begin
            failed++;
            $display("FAIL be_old_o: got %h want %h", bus_o.rd_dataB, 32'hAAAAAAAA);
        end
        tick();
        bus_d.wr_be0   = 4'b0000;
        bus_d.wr_data0 = 32'h00000000;
        tick();
        idle_writes();
        #1;
        tests++;
        if (bus_o.rd_dataB !== 32'hAA34AA78) begin
            failed++;
            $display("FAIL be_stored_o: got %h want %h", bus_o.rd_dataB, 32'hAA34AA78);
        end
        tests++;
        if (bus_d.rd_dataB !== 32'hAA34AA78) begin
            failed++;
            $display("FAIL be_zero_noop_d: got %h want %h", bus_d.rd_dataB, 32'hAA34AA78);
        end
    endtask

    task automatic test_bypass;
        bus_d.rd_addrB = 5'd7;
        bus_d.wr_en1   = 1'b1;
        bus_d.wr_addr1 = 5'd7;
        bus_d.wr_data1 = 32'h0000BEEF;
        #1;
        tests++;
        if (bus_d.rd_dataB !== 32'h0000BEEF) begin
            failed++;
            $display("FAIL bypass_same_cycle_d: got %h want %h", bus_d.rd_dataB, 32'h0000BEEF);
        end
        tests++;
        if (bus_o.rd_dataB !== 32'h0) begin
            failed++;
            $display("FAIL bypass_off_old_o: got %h want %h", bus_o.rd_dataB, 32'h0);
        end
        tick();
        idle_writes();
        #1;
        tests++;
        if (bus_o.rd_dataB !== 32'h0000BEEF) begin
            failed++;
            $display("FAIL bypass_off_after_edge_o: got %h want %h", bus_o.rd_dataB, 32'h0000BEEF);
        end
    endtask

    task automatic test_zero_reg;
        bus_d.wr_en0   = 1'b1;
        bus_d.wr_be0   = 4'hF;
        bus_d.wr_addr0 = 5'd0;
        bus_d.wr_data0 = 32'hFFFFFFFF;
        bus_d.wr_en1   = 1'b1;
        bus_d.wr_addr1 = 5'd0;
        bus_d.wr_data1 = 32'hFFFFFFFF;
        bus_d.rd_addrA = 5'd0;
        #1;
        tests++;
        if (bus_d.rd_dataA !== 32'h0) begin
            failed++;
            $display("FAIL zero_no_bypass_d: got %h want %h", bus_d.rd_dataA, 32'h0);
        end
        tick();
        idle_writes();
        #1;
        tests++;
        if (bus_d.rd_dataA !== 32'h0) begin
            failed++;
            $display("FAIL zero_read_d: got %h want %h", bus_d.rd_dataA, 32'h0);
        end
        tests++;
        if (bus_d.wr_conflict !== 1'b1) begin
            failed++;
            $display("FAIL zero_conflict_d: got %b want 1", bus_d.wr_conflict);
        end
        tests++;
        if (bus_o.rd_dataA !== 32'hFFFFFFFF) begin
            failed++;
            $display("FAIL zero_off_read_o: got %h want %h", bus_o.rd_dataA, 32'hFFFFFFFF);
        end
        tests++;
        if (bus_o.wr_conflict !== 1'b1) begin
            failed++;
            $display("FAIL zero_off_conflict_o: got %b want 1", bus_o.wr_conflict);
        end
    endtask

    task automatic test_read_latency;
        bus_d.wr_en0   = 1'b1;
        bus_d.wr_be0   = 4'hF;
        bus_d.wr_addr0 = 5'd3;
        bus_d.wr_data0 = 32'h03030303;
        bus_d.wr_en1   = 1'b1;
        bus_d.wr_addr1 = 5'd4;
        bus_d.wr_data1 = 32'h04040404;
        tick();
        idle_writes();
        bus_d.rd_addrA = 5'd3;
        tick();
        tests++;
        if (bus_r.rd_dataA !== 32'h03030303) begin
            failed++;
            $display("FAIL lat_addr3_r: got %h want %h", bus_r.rd_dataA, 32'h03030303);
        end
        bus_d.rd_addrA = 5'd4;
        #1;
        tests++;
        if (bus_r.rd_dataA !== 32'h03030303) begin
            failed++;
            $display("FAIL lat_hold_r: got %h want %h", bus_r.rd_dataA, 32'h03030303);
        end
        tick();
        tests++;
        if (bus_r.rd_dataA !== 32'h04040404) begin
            failed++;
            $display("FAIL lat_addr4_r: got %h want %h", bus_r.rd_dataA, 32'h04040404);
        end
        bus_d.wr_en0   = 1'b1;
        bus_d.wr_be0   = 4'hF;
        bus_d.wr_addr0 = 5'd3;
        bus_d.wr_data0 = 32'hDEADBEEF;
        rst = 1'b1;
        tick();
        tests++;
        if (bus_r.rd_dataA !== 32'h0) begin
            failed++;
            $display("FAIL lat_rst_outreg_r: got %h want %h", bus_r.rd_dataA, 32'h0);
        end
        rst = 1'b0;
        idle_writes();
        bus_d.rd_addrA = 5'd3;
        bus_d.rd_addrB = 5'd4;
        #1;
        tests++;
        if (bus_d.rd_dataA !== 32'h0) begin
            failed++;
            $display("FAIL lat_rst_no_write_d: got %h want %h", bus_d.rd_dataA, 32'h0);
        end
        tests++;
        if (bus_d.rd_dataB !== 32'h0) begin
            failed++;
            $display("FAIL lat_rst_clears_d: got %h want %h", bus_d.rd_dataB, 32'h0);
        end
        tick();
        tests++;
        if (bus_r.rd_dataA !== 32'h0) begin
            failed++;
            $display("FAIL lat_rst_reg3_r: got %h want %h", bus_r.rd_dataA, 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_d.rd_addrA = 5'd0;
        bus_d.rd_addrB = 5'd0;
        idle_writes();
        test_reset();
        test_basic_write();
        test_conflict();
        test_byte_enable();
        test_bypass();
        test_zero_reg();
        test_read_latency();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
